// File: rtl/cu_seq.sv
// Registered RV32I/RV32M control unit with a multi-cycle sequencer for mul/div ops.
// State table:  IDLE | decode and register the bundle; launch M ops
//               BUSY | mul/div in flight, front end stalled until cnt reaches 0
module cu_seq #(
    parameter int ALUCTRL_W = 5,
    parameter bit EN_M      = 1'b1,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_i,
    input  logic [6:0]           id_opcode_i,
    input  logic [2:0]           id_func3_i,
    input  logic [6:0]           id_func7_i,
    input  logic                 flush_i,
    output logic                 cu_stall_o,
    output logic                 cu_md_start_o,
    output logic                 cu_valid_o,
    output logic [ALUCTRL_W-1:0] cu_ALUctrl_o,
    output logic                 cu_regwrite_o,
    output logic                 cu_memread_o,
    output logic                 cu_memwrite_o,
    output logic                 cu_branch_o,
    output logic                 cu_jump_o,
    output logic                 cu_alusrc_o,
    output logic                 cu_illegal_o
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX) + 1;
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;
    localparam logic [4:0] ALU_MUL   = 5'd11;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] alu;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       alusrc;
        logic       illegal;
    } bundle_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bundle_t          bund_q, bund_d;
    bundle_t          dec;
    logic             dec_m;
    logic             stall_c, start_c;

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.alu   = ALU_ADD;
        dec_m     = 1'b0;
        unique case (id_opcode_i)
            OPC_OP: begin
                dec.regwrite = 1'b1;
                if (id_func7_i == F7_BASE) begin
                    unique case (id_func3_i)
                        3'b000:  dec.alu = ALU_ADD;
                        3'b001:  dec.alu = ALU_SLL;
                        3'b010:  dec.alu = ALU_SLT;
                        3'b011:  dec.alu = ALU_SLTU;
                        3'b100:  dec.alu = ALU_XOR;
                        3'b101:  dec.alu = ALU_SRL;
                        3'b110:  dec.alu = ALU_OR;
                        default: dec.alu = ALU_AND;
                    endcase
                end else if (id_func7_i == F7_ALT && id_func3_i == 3'b000) begin
                    dec.alu = ALU_SUB;
                end else if (id_func7_i == F7_ALT && id_func3_i == 3'b101) begin
                    dec.alu = ALU_SRA;
                end else if (EN_M && id_func7_i == F7_MULD) begin
                    dec_m   = 1'b1;
                    dec.alu = ALU_MUL + {2'b00, id_func3_i};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_IMM: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                unique case (id_func3_i)
                    3'b000: dec.alu = ALU_ADD;
                    3'b001: begin
                        dec.alu     = ALU_SLL;
                        dec.illegal = (id_func7_i != F7_BASE);
                    end
                    3'b010: dec.alu = ALU_SLT;
                    3'b011: dec.alu = ALU_SLTU;
                    3'b100: dec.alu = ALU_XOR;
                    3'b101: begin
                        if (id_func7_i == F7_BASE)     dec.alu = ALU_SRL;
                        else if (id_func7_i == F7_ALT) dec.alu = ALU_SRA;
                        else                           dec.illegal = 1'b1;
                    end
                    3'b110:  dec.alu = ALU_OR;
                    default: dec.alu = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OPC_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu    = ALU_SUB;
            end
            OPC_JAL, OPC_JALR: begin
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_LUI: begin
                dec.alu      = ALU_PASSB;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal encoding still travels down the pipe so EX can trap on it.
        if (dec.illegal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec_m       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bund_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bund_q  <= bund_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bund_d  = '0;
        stall_c = 1'b0;
        start_c = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (id_valid_i) begin
                        if (dec_m) begin
                            stall_c = 1'b1;
                            start_c = 1'b1;
                            state_d = S_BUSY;
                            cnt_d   = id_func3_i[2] ? DIV_LD : MUL_LD;
                        end else begin
                            bund_d = dec;
                        end
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        stall_c = 1'b1;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        // ID has held the M op throughout; it is decoded once more here.
                        bund_d  = dec;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cu_stall_o    = stall_c & ~rst;
    assign cu_md_start_o = start_c & ~rst;
    assign cu_valid_o    = bund_q.valid;
    assign cu_ALUctrl_o  = ALUCTRL_W'(bund_q.alu);
    assign cu_regwrite_o = bund_q.regwrite;
    assign cu_memread_o  = bund_q.memread;
    assign cu_memwrite_o = bund_q.memwrite;
    assign cu_branch_o   = bund_q.branch;
    assign cu_jump_o     = bund_q.jump;
    assign cu_alusrc_o   = bund_q.alusrc;
    assign cu_illegal_o  = bund_q.illegal;

endmodule

// File: tb/tb_cu_seq.sv
// Directed vector bench for cu_seq: decode table plus mul/div, flush, reset and EN_M=0 sequences.
module tb_cu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_i;
    logic [6:0] id_opcode_i;
    logic [2:0] id_func3_i;
    logic [6:0] id_func7_i;
    logic       flush_i;

    logic       stall, start, valid, rw, mr, mw, br, jp, src, ill;
    logic [4:0] alu;
    logic       n_stall, n_start, n_valid, n_rw, n_mr, n_mw, n_br, n_jp, n_src, n_ill;
    logic [4:0] n_alu;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    cu_seq dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
        .id_func3_i(id_func3_i), .id_func7_i(id_func7_i), .flush_i(flush_i),
        .cu_stall_o(stall), .cu_md_start_o(start), .cu_valid_o(valid), .cu_ALUctrl_o(alu),
        .cu_regwrite_o(rw), .cu_memread_o(mr), .cu_memwrite_o(mw), .cu_branch_o(br),
        .cu_jump_o(jp), .cu_alusrc_o(src), .cu_illegal_o(ill)
    );

    cu_seq #(.EN_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
        .id_func3_i(id_func3_i), .id_func7_i(id_func7_i), .flush_i(flush_i),
        .cu_stall_o(n_stall), .cu_md_start_o(n_start), .cu_valid_o(n_valid), .cu_ALUctrl_o(n_alu),
        .cu_regwrite_o(n_rw), .cu_memread_o(n_mr), .cu_memwrite_o(n_mw), .cu_branch_o(n_br),
        .cu_jump_o(n_jp), .cu_alusrc_o(n_src), .cu_illegal_o(n_ill)
    );

    // Bundle packing order: {valid, alu[4:0], regwrite, memread, memwrite, branch, jump, alusrc, illegal}
    function automatic logic [12:0] pk(input logic v, input logic [4:0] a, input logic w, input logic r,
                                       input logic m, input logic b, input logic j, input logic s,
                                       input logic i);
        return {v, a, w, r, m, b, j, s, i};
    endfunction

    function automatic logic [12:0] got_b();
        return {valid, alu, rw, mr, mw, br, jp, src, ill};
    endfunction

    function automatic logic [12:0] got_n();
        return {n_valid, n_alu, n_rw, n_mr, n_mw, n_br, n_jp, n_src, n_ill};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        id_valid_i  = v;
        id_opcode_i = opc;
        id_func3_i  = f3;
        id_func7_i  = f7;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        v;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input string n, input logic v, input logic [6:0] o, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [12:0] e);
        vec_t t;
        t.name = n; t.v = v; t.opc = o; t.f3 = f3; t.f7 = f7; t.exp = e;
        return t;
    endfunction

    localparam logic [12:0] ILL = 13'b1_00000_0000001;

    initial begin
        int cyc;
        int starts;
        logic bub_bad;

        vecs.push_back(mkv("sub",    1, 7'b0110011, 3'b000, 7'b0100000, pk(1, 5'd1,  1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mkv("add",    1, 7'b0110011, 3'b000, 7'b0000000, pk(1, 5'd0,  1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mkv("sra",    1, 7'b0110011, 3'b101, 7'b0100000, pk(1, 5'd7,  1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mkv("or",     1, 7'b0110011, 3'b110, 7'b0000000, pk(1, 5'd8,  1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mkv("sltu",   1, 7'b0110011, 3'b011, 7'b0000000, pk(1, 5'd4,  1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mkv("r_ill",  1, 7'b0110011, 3'b001, 7'b0100000, ILL));
        vecs.push_back(mkv("srai",   1, 7'b0010011, 3'b101, 7'b0100000, pk(1, 5'd7,  1, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkv("slli_b", 1, 7'b0010011, 3'b001, 7'b0100000, ILL));
        vecs.push_back(mkv("sltiu",  1, 7'b0010011, 3'b011, 7'b1010101, pk(1, 5'd4,  1, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkv("load",   1, 7'b0000011, 3'b010, 7'b0000000, pk(1, 5'd0,  1, 1, 0, 0, 0, 1, 0)));
        vecs.push_back(mkv("store",  1, 7'b0100011, 3'b010, 7'b0000000, pk(1, 5'd0,  0, 0, 1, 0, 0, 1, 0)));
        vecs.push_back(mkv("branch", 1, 7'b1100011, 3'b000, 7'b0000000, pk(1, 5'd1,  0, 0, 0, 1, 0, 0, 0)));
        vecs.push_back(mkv("jal",    1, 7'b1101111, 3'b000, 7'b0000000, pk(1, 5'd0,  1, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mkv("jalr",   1, 7'b1100111, 3'b000, 7'b0000000, pk(1, 5'd0,  1, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mkv("lui",    1, 7'b0110111, 3'b000, 7'b0000000, pk(1, 5'd10, 1, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkv("auipc",  1, 7'b0010111, 3'b000, 7'b0000000, pk(1, 5'd0,  1, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkv("opc_ff", 1, 7'b1111111, 3'b000, 7'b0000000, ILL));
        vecs.push_back(mkv("bubble", 0, 7'b0110011, 3'b000, 7'b0000000, 13'd0));

        // Reset with an M op presented: even combinational outputs must stay low.
        rst = 1'b1;
        flush_i = 1'b0;
        drive(1, 7'b0110011, 3'b000, 7'b0000001);
        #12;
        check("reset_outs", {3'b0, stall, start, 11'b0} | {3'b0, got_b()}, 16'd0);
        @(negedge clk);
        drive(0, 7'b0, 3'b0, 7'b0);
        rst = 1'b0;
        tick();

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].opc, vecs[k].f3, vecs[k].f7);
            @(negedge clk);
            check({vecs[k].name, "_stall"}, {14'b0, stall, start}, 16'd0);
            tick();
            check(vecs[k].name, {3'b0, got_b()}, {3'b0, vecs[k].exp});
        end

        // MUL, latency 2; the EN_M=0 instance sees the same op as illegal.
        drive(1, 7'b0110011, 3'b000, 7'b0000001);
        @(negedge clk);
        check("mul_c0", {14'b0, stall, start}, 16'b11);
        check("nom_c0", {14'b0, n_stall, n_start}, 16'b00);
        tick();
        check("mul_bub", {3'b0, got_b()}, 16'd0);
        check("nom_ill", {3'b0, got_n()}, {3'b0, ILL});
        @(negedge clk);
        check("mul_c1", {14'b0, stall, start}, 16'b10);
        tick();
        @(negedge clk);
        check("mul_c2", {14'b0, stall, start}, 16'b00);
        tick();
        check("mul_res", {3'b0, got_b()}, {3'b0, pk(1, 5'd11, 1, 0, 0, 0, 0, 0, 0)});
        drive(0, 7'b0, 3'b0, 7'b0);
        tick();

        // DIVU, latency 33.
        drive(1, 7'b0110011, 3'b101, 7'b0000001);
        cyc = 0;
        starts = 0;
        bub_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!stall || cyc > 100) break;
            cyc++;
            if (start) starts++;
            if (valid) bub_bad = 1'b1;
        end
        check("divu_stall_cycles", 16'(cyc), 16'd33);
        check("divu_starts", 16'(starts), 16'd1);
        check("divu_bubble", {15'b0, bub_bad}, 16'd0);
        check("divu_last_start", {15'b0, start}, 16'd0);
        tick();
        check("divu_res", {3'b0, got_b()}, {3'b0, pk(1, 5'd16, 1, 0, 0, 0, 0, 0, 0)});
        drive(0, 7'b0, 3'b0, 7'b0);
        tick();

        // Flush during DIV at cycle 10, then an ADD.
        drive(1, 7'b0110011, 3'b100, 7'b0000001);
        @(negedge clk);
        check("div_c0", {14'b0, stall, start}, 16'b11);
        for (int i = 0; i < 10; i++) tick();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_comb", {14'b0, stall, start}, 16'b00);
        tick();
        flush_i = 1'b0;
        check("flush_bub", {3'b0, got_b()}, 16'd0);
        drive(1, 7'b0110011, 3'b000, 7'b0000000);
        @(negedge clk);
        check("post_flush_idle", {14'b0, stall, start}, 16'b00);
        tick();
        check("post_flush_add", {3'b0, got_b()}, {3'b0, pk(1, 5'd0, 1, 0, 0, 0, 0, 0, 0)});

        // Reset asserted mid-BUSY.
        drive(1, 7'b0110011, 3'b110, 7'b0000001);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check("rst_busy", {1'b0, stall, start, got_b()}, 16'd0);
        drive(0, 7'b0, 3'b0, 7'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle", {14'b0, stall, start}, 16'd0);
        drive(1, 7'b0110111, 3'b000, 7'b0000000);
        tick();
        check("rst_lui", {3'b0, got_b()}, {3'b0, pk(1, 5'd10, 1, 0, 0, 0, 0, 1, 0)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
Parametrised, registered successor to the combinational control unit. Decodes RV32I/RV32M opcode/func3/func7 from ID and drives a registered control bundle into id_ex_reg. Adds a multi-cycle sequencer for M-extension ops: it pulses a start to the mul/div unit and stalls the front end for a programmable latency. Also adds flush handling and illegal-instruction flagging.

Parameters:
ALUCTRL_W, 5, width of cu_ALUctrl_o; must be >= 5, upper bits zero-extended.
EN_M, 1, 1 = decode RV32M; 0 = M ops flagged illegal.
MUL_LAT, 2, stall cycles for MUL/MULH/MULHSU/MULHU (>= 1).
DIV_LAT, 33, stall cycles for DIV/DIVU/REM/REMU (>= 1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
id_valid_i  in  1  ID holds a valid instruction
id_opcode_i  in  7  opcode
id_func3_i  in  3  func3
id_func7_i  in  7  func7
flush_i  in  1  pipeline flush (branch/jump redirect)
cu_stall_o  out  1  combinational; hold PC/IF/ID
cu_md_start_o  out  1  one-cycle start pulse to mul/div unit
cu_valid_o  out  1  registered; bundle valid for EX
cu_ALUctrl_o  out  ALUCTRL_W  registered ALU operation
cu_regwrite_o  out  1  registered
cu_memread_o  out  1  registered
cu_memwrite_o  out  1  registered
cu_branch_o  out  1  registered
cu_jump_o  out  1  registered
cu_alusrc_o  out  1  registered; 1 = immediate operand
cu_illegal_o  out  1  registered; illegal encoding

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, counter=0. All outputs are 0, including cu_stall_o and cu_md_start_o.
- ALUctrl encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB(LUI)=10.
  - MUL=11, MULH=12, MULHSU=13, MULHU=14, DIV=15, DIVU=16, REM=17, REMU=18.
- Decode rules:
  - OP (0110011): func7 0000000/0100000 gives the ALU ops; 0100000 is valid only with func3 000 (SUB) or 101 (SRA). func7 0000001 is an M op when EN_M=1.
  - OP-IMM (0010011): alusrc=1. SRAI when func3=101 and func7=0100000. Shift with any other func7 is illegal.
  - LOAD: memread, regwrite, ADD, alusrc. STORE: memwrite, ADD, alusrc. BRANCH: branch, SUB. JAL/JALR: jump, regwrite, ADD. LUI: PASSB, regwrite, alusrc. AUIPC: ADD, regwrite, alusrc.
  - Anything else is illegal: illegal=1, valid=1, regwrite/memread/memwrite/branch/jump=0, ALUctrl=0.
- Non-M instruction: control bundle registered at the next edge, latency 1, cu_stall_o=0.
- id_valid_i=0 (no flush): next edge drives a bubble, i.e. cu_valid_o=0 and all other registered outputs 0.
- FSM IDLE: valid M op with flush_i=0:
  - cu_stall_o=1 and cu_md_start_o=1 combinationally this cycle.
  - Next edge: state=BUSY, cnt=LAT-1, with LAT = MUL_LAT if func3[2]=0, else DIV_LAT. Registered outputs become a bubble.
- FSM BUSY:
  - cnt!=0: cu_stall_o=1, cnt decrements each edge.
  - cnt==0: cu_stall_o=0, cu_md_start_o=0. Next edge loads the M-op bundle (valid=1, regwrite=1, M ALUctrl) and returns to IDLE.
  - Total stall cycles equal LAT.
- ID holds opcode/func fields stable while cu_stall_o=1; the CU decodes the held inputs in the final BUSY cycle.
- flush_i=1, any state:
  - cu_stall_o=0 and cu_md_start_o=0 combinationally.
  - Next edge: state=IDLE, cnt=0, bubble on all registered outputs. Flush has priority over every other event.
- cu_md_start_o is never asserted in BUSY; a back-to-back M op restarts only after returning to IDLE.
- Reset asserted mid-BUSY: immediate return to reset values; no start is re-issued.

Test Plan:
- Reset: assert rst mid-operation with garbage inputs -> all outputs 0 immediately, state IDLE after release.
- R-type: opcode=0110011, func3=000, func7=0100000, valid -> next cycle valid=1, ALUctrl=1 (SUB), regwrite=1, alusrc=0, stall never high.
- MUL, MUL_LAT=2: opcode=0110011, func7=0000001, func3=000 held -> cycle0 stall=1 and start=1; cycle1 stall=1, start=0; cycle2 stall=0; cycle3 valid=1, ALUctrl=11, regwrite=1.
- DIVU, DIV_LAT=33: func3=101 -> exactly one start pulse, stall high 33 cycles, then ALUctrl=16, valid=1.
- Flush during DIV at cycle 10 -> same-cycle stall=0; next cycle bubble (valid=0), state IDLE; a new ADD the following cycle gives valid=1, ALUctrl=0 after one cycle.
- Illegal: opcode=1111111, and separately an M op with EN_M=0 -> illegal=1, valid=1, regwrite=0, no start pulse, no stall.
